// File: rtl/demux8_pkg.sv
// Shared constants and types for the 8-lane 64-bit demux loader.
package demux8_pkg;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 4;
  localparam int LANES  = 8;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_DIR  = 1'b1;

  localparam logic [LANES-1:0] LANE_ALL = 8'hFF;

  typedef logic [LANES-1:0]  lane_mask_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/demux8_sel_decode.sv
// 4-bit lane code to one-hot lane mask; codes 8..15 fall back to lane 1.
module demux8_sel_decode
  import demux8_pkg::*;
(
  input  logic [SEL_W-1:0] code_i,
  output lane_mask_t       onehot_o
);

  // Decode the code into a one-hot lane mask.
  always_comb begin
    onehot_o = 8'b0000_0001;
    case (code_i)
      4'd0:    onehot_o = 8'b0000_0001;
      4'd1:    onehot_o = 8'b0000_0010;
      4'd2:    onehot_o = 8'b0000_0100;
      4'd3:    onehot_o = 8'b0000_1000;
      4'd4:    onehot_o = 8'b0001_0000;
      4'd5:    onehot_o = 8'b0010_0000;
      4'd6:    onehot_o = 8'b0100_0000;
      4'd7:    onehot_o = 8'b1000_0000;
      default: onehot_o = 8'b0000_0001;
    endcase
  end

endmodule

// File: rtl/demux8_loader.sv
// Distributes a 64-bit word stream into eight registered lanes, in round-robin
// or directed order, holding each completed bank until the consumer acks it.
module demux8_loader
  import demux8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  select,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              bank_ack,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [DATA_W-1:0] out_4,
  output logic [DATA_W-1:0] out_5,
  output logic [DATA_W-1:0] out_6,
  output logic [DATA_W-1:0] out_7,
  output logic [DATA_W-1:0] out_8,
  output logic [LANES-1:0]  lane_valid,
  output logic              bank_valid,
  output logic [2:0]        wr_ptr,
  output logic              err_overwrite
);

  word_t      lane_q [LANES];
  lane_mask_t lane_valid_q, lane_valid_d;
  logic       bank_valid_q, bank_valid_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic       in_ready_q, in_ready_d;
  logic       err_q, err_d;

  lane_mask_t ptr_oh_s, sel_oh_s, tgt_s;
  logic       accept_s;

  demux8_sel_decode u_ptr_dec (
    .code_i   ({1'b0, wr_ptr_q}),
    .onehot_o (ptr_oh_s)
  );

  demux8_sel_decode u_sel_dec (
    .code_i   (select),
    .onehot_o (sel_oh_s)
  );

  // Next-state for lane flags, bank handshake, round-robin pointer and ready.
  always_comb begin
    accept_s     = in_valid & in_ready_q;
    tgt_s        = (mode == MODE_DIR) ? sel_oh_s : ptr_oh_s;
    lane_valid_d = lane_valid_q;
    bank_valid_d = bank_valid_q;
    wr_ptr_d     = wr_ptr_q;
    err_d        = 1'b0;
    if (bank_valid_q) begin
      if (bank_ack) begin
        bank_valid_d = 1'b0;
        lane_valid_d = 8'h00;
      end else begin
        bank_valid_d = 1'b1;
      end
    end else if (accept_s) begin
      lane_valid_d = lane_valid_q | tgt_s;
      if (mode == MODE_DIR) begin
        err_d        = |(lane_valid_q & tgt_s);
        bank_valid_d = in_last | (lane_valid_d == LANE_ALL);
      end else begin
        bank_valid_d = in_last | (wr_ptr_q == 3'd7);
        wr_ptr_d     = bank_valid_d ? 3'd0 : (wr_ptr_q + 3'd1);
      end
    end else begin
      bank_valid_d = 1'b0;
    end
    // Ready tracks the next bank state so a completed bank never takes a word.
    in_ready_d = ~bank_valid_d;
  end

  // State and lane data registers; reset discards any partial bank silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= 64'd0;
      lane_valid_q <= 8'h00;
      bank_valid_q <= 1'b0;
      wr_ptr_q     <= 3'd0;
      in_ready_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (accept_s && tgt_s[i]) lane_q[i] <= in_data;
      end
      lane_valid_q <= lane_valid_d;
      bank_valid_q <= bank_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      in_ready_q   <= in_ready_d;
      err_q        <= err_d;
    end
  end

  assign out_1         = lane_q[0];
  assign out_2         = lane_q[1];
  assign out_3         = lane_q[2];
  assign out_4         = lane_q[3];
  assign out_5         = lane_q[4];
  assign out_6         = lane_q[5];
  assign out_7         = lane_q[6];
  assign out_8         = lane_q[7];
  assign lane_valid    = lane_valid_q;
  assign bank_valid    = bank_valid_q;
  assign wr_ptr        = wr_ptr_q;
  assign in_ready      = in_ready_q;
  assign err_overwrite = err_q;

endmodule

// File: tb/tb_demux8_loader.sv
// Directed and scoreboarded random checks for demux8_loader.
module tb_demux8_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [3:0]  select;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        bank_ack;
  logic [63:0] out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8;
  logic [7:0]  lane_valid;
  logic        bank_valid;
  logic [2:0]  wr_ptr;
  logic        err_overwrite;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux8_loader dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .select(select),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .bank_ack(bank_ack),
    .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
    .out_5(out_5), .out_6(out_6), .out_7(out_7), .out_8(out_8),
    .lane_valid(lane_valid), .bank_valid(bank_valid), .wr_ptr(wr_ptr),
    .err_overwrite(err_overwrite)
  );

  function automatic logic [63:0] lane_out(input int i);
    case (i)
      0: return out_1;
      1: return out_2;
      2: return out_3;
      3: return out_4;
      4: return out_5;
      5: return out_6;
      6: return out_7;
      7: return out_8;
      default: return 64'hX;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; bank_ack = 1'b0; in_last = 1'b0;
    mode = 1'b0; select = 4'd0; in_data = 64'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; bank_ack = 1'b0; in_last = 1'b0;
    mode = 1'b0; select = 4'd0; in_data = 64'd0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (lane_out(i) !== 64'd0) begin
        n_err++; $display("FAIL reset_out%0d got %h want 0", i + 1, lane_out(i));
      end
    end
    n_vec++;
    if ({lane_valid, bank_valid, wr_ptr, err_overwrite, in_ready} !== 14'd0) begin
      n_err++; $display("FAIL reset_status got lv=%h bv=%b ptr=%0d err=%b rdy=%b want all 0",
                        lane_valid, bank_valid, wr_ptr, err_overwrite, in_ready);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_auto_fill();
    logic [63:0] w;
    mode = 1'b0; in_last = 1'b0; bank_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = 64'h11 * (i + 1);
      in_valid = 1'b1; in_data = w;
      tick();
      n_vec++;
      if (lane_out(i) !== w) begin
        n_err++; $display("FAIL auto_out%0d got %h want %h", i + 1, lane_out(i), w);
      end
      if (i < 7) begin
        n_vec++;
        if (in_ready !== 1'b1 || bank_valid !== 1'b0 || wr_ptr !== 3'(i + 1)) begin
          n_err++; $display("FAIL auto_progress%0d got rdy=%b bv=%b ptr=%0d want 1 0 %0d",
                            i, in_ready, bank_valid, wr_ptr, i + 1);
        end
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (bank_valid !== 1'b1 || in_ready !== 1'b0 || lane_valid !== 8'hFF || wr_ptr !== 3'd0) begin
      n_err++; $display("FAIL auto_bank got bv=%b rdy=%b lv=%h ptr=%0d want 1 0 ff 0",
                        bank_valid, in_ready, lane_valid, wr_ptr);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 64'h99; mode = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (in_ready !== 1'b0 || bank_valid !== 1'b1 || out_1 !== 64'h11) begin
        n_err++; $display("FAIL bp_hold%0d got rdy=%b bv=%b out_1=%h want 0 1 11",
                          c, in_ready, bank_valid, out_1);
      end
    end
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    n_vec++;
    if (bank_valid !== 1'b0 || lane_valid !== 8'h00 || in_ready !== 1'b1 || out_1 !== 64'h11) begin
      n_err++; $display("FAIL bp_ack got bv=%b lv=%h rdy=%b out_1=%h want 0 00 1 11",
                        bank_valid, lane_valid, in_ready, out_1);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_1 !== 64'h99 || lane_valid !== 8'h01) begin
      n_err++; $display("FAIL bp_land got out_1=%h lv=%h want 99 01", out_1, lane_valid);
    end
    for (int i = 1; i < 8; i++) begin
      n_vec++;
      if (lane_out(i) !== 64'h11 * (i + 1)) begin
        n_err++; $display("FAIL bp_stale_out%0d got %h want %h", i + 1, lane_out(i), 64'h11 * (i + 1));
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0]  sels [4];
    logic [63:0] dats [4];
    logic        errs [4];
    sels = '{4'd7, 4'd3, 4'd12, 4'd0};
    dats = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
             64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
    errs = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; select = sels[k]; in_data = dats[k];
      tick();
      n_vec++;
      if (err_overwrite !== errs[k]) begin
        n_err++; $display("FAIL dir_err%0d got %b want %b", k, err_overwrite, errs[k]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (err_overwrite !== 1'b0) begin
      n_err++; $display("FAIL dir_err_pulse got %b want 0", err_overwrite);
    end
    n_vec++;
    if (out_8 !== dats[0] || out_4 !== dats[1] || out_1 !== dats[3]) begin
      n_err++; $display("FAIL dir_data got out_8=%h out_4=%h out_1=%h", out_8, out_4, out_1);
    end
    n_vec++;
    if (lane_valid !== 8'h89 || wr_ptr !== 3'd0 || bank_valid !== 1'b0) begin
      n_err++; $display("FAIL dir_status got lv=%h ptr=%0d bv=%b want 89 0 0",
                        lane_valid, wr_ptr, bank_valid);
    end
  endtask

  task automatic test_in_last();
    do_reset();
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 64'h100 + 64'(k); in_last = (k == 2);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_vec++;
    if (bank_valid !== 1'b1 || lane_valid !== 8'h07 || wr_ptr !== 3'd0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL last_bank got bv=%b lv=%h ptr=%0d rdy=%b want 1 07 0 0",
                        bank_valid, lane_valid, wr_ptr, in_ready);
    end
    n_vec++;
    if (out_3 !== 64'h102) begin
      n_err++; $display("FAIL last_out3 got %h want 102", out_3);
    end
  endtask

  task automatic test_reset_mid_bank();
    do_reset();
    mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 64'h200 + 64'(k);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_vec++;
    if ({lane_valid, bank_valid, wr_ptr, err_overwrite, in_ready} !== 14'd0 ||
        out_1 !== 64'd0 || out_5 !== 64'd0) begin
      n_err++; $display("FAIL midrst_state got lv=%h ptr=%0d rdy=%b out_1=%h out_5=%h want zeros",
                        lane_valid, wr_ptr, in_ready, out_1, out_5);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_ready got %b want 1", in_ready);
    end
    in_valid = 1'b1; in_data = 64'h5A;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_1 !== 64'h5A || lane_valid !== 8'h01 || wr_ptr !== 3'd1) begin
      n_err++; $display("FAIL midrst_first got out_1=%h lv=%h ptr=%0d want 5a 01 1",
                        out_1, lane_valid, wr_ptr);
    end
  endtask

  task automatic test_random();
    logic [63:0] m_lane [8];
    logic [7:0]  m_lv;
    logic        m_bv, m_rdy, m_err, acc;
    logic [2:0]  m_ptr;
    int          tgt;
    do_reset();
    for (int i = 0; i < 8; i++) m_lane[i] = 64'd0;
    m_lv = 8'h00; m_bv = 1'b0; m_rdy = 1'b1; m_err = 1'b0; m_ptr = 3'd0;
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(9) < 7);
      bank_ack = ($urandom_range(9) < 3);
      mode     = 1'($urandom_range(1));
      select   = 4'($urandom_range(15));
      in_last  = ($urandom_range(15) == 0);
      in_data  = {$urandom, $urandom};
      acc   = in_valid && m_rdy;
      m_err = 1'b0;
      if (m_bv) begin
        if (bank_ack) begin m_bv = 1'b0; m_lv = 8'h00; end
      end else if (acc) begin
        if (mode) tgt = (select < 4'd8) ? int'(select) : 0;
        else      tgt = int'(m_ptr);
        m_err = mode && m_lv[tgt];
        m_lane[tgt] = in_data;
        m_lv[tgt] = 1'b1;
        if (mode) begin
          m_bv = in_last || (m_lv == 8'hFF);
        end else begin
          m_bv  = in_last || (m_ptr == 3'd7);
          m_ptr = m_bv ? 3'd0 : m_ptr + 3'd1;
        end
      end
      m_rdy = !m_bv;
      tick();
      n_vec++;
      if (lane_valid !== m_lv || bank_valid !== m_bv || wr_ptr !== m_ptr ||
          in_ready !== m_rdy || err_overwrite !== m_err) begin
        n_err++; $display("FAIL rnd_status cyc %0d got lv=%h bv=%b ptr=%0d rdy=%b err=%b want %h %b %0d %b %b",
                          c, lane_valid, bank_valid, wr_ptr, in_ready, err_overwrite,
                          m_lv, m_bv, m_ptr, m_rdy, m_err);
      end
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (lane_out(i) !== m_lane[i]) begin
          n_err++; $display("FAIL rnd_out%0d cyc %0d got %h want %h", i + 1, c, lane_out(i), m_lane[i]);
        end
      end
      n_vec++;
      if (in_ready === 1'b1 && bank_valid === 1'b1) begin
        n_err++; $display("FAIL rnd_ready_in_bank cyc %0d got rdy=1 bv=1 want not both", c);
      end
    end
    in_valid = 1'b0; bank_ack = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    test_reset();
    test_auto_fill();
    test_backpressure();
    test_directed();
    test_in_last();
    test_reset_mid_bank();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux8_loader.md
Name: demux8_loader

Overview:
- Write-side counterpart of the 8:1 64-bit lane selector in the accelerator datapath.
- Takes one 64-bit word stream and distributes it into eight registered 64-bit lane outputs, out_1..out_8, which feed the PE array.
- Lanes are filled in round-robin (auto) or by explicit 4-bit select (directed). A completed bank is held with a valid/ack handshake and back-pressures the input until the consumer releases it.

Parameters:
DATA_W, 64, width of the input word and of each lane output
SEL_W, 4, width of select; codes 0..7 map to lanes 1..8
LANES, 8, lane count; fixed, since the port list is unrolled

Ports:
clk  in  1  clock, all logic on the rising edge
rst_n  in  1  reset, synchronous, active-low
mode  in  1  0 = auto round-robin, 1 = directed by select; sampled per accepted word
select  in  SEL_W  destination lane in directed mode
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word (registered)
in_data  in  DATA_W  input word
in_last  in  1  word closes the current bank early
bank_ack  in  1  consumer releases the completed bank
out_1..out_8  out  DATA_W each  lane registers
lane_valid  out  8  bit i set when lane i+1 has been written in the current bank
bank_valid  out  1  bank complete, outputs stable
wr_ptr  out  3  next auto-mode lane (status)
err_overwrite  out  1  one-cycle pulse: directed write hit a lane already valid in this bank

Behaviour:
- Reset: sampled only on the clk edge; it has priority over every other input.
  - All out_x = 0, lane_valid = 0, bank_valid = 0, wr_ptr = 0, err_overwrite = 0, in_ready = 0.
  - in_ready rises on the first edge after rst_n is high.
  - Reset mid-bank discards any partial bank without an error indication.
- Accept: accept = in_valid & in_ready.
  - On accept, the target out_x and its lane_valid bit update at that edge (1-cycle latency).
  - in_data is never dropped or duplicated.
- Auto mode (mode = 0):
  - Target lane = wr_ptr + 1.
  - wr_ptr increments mod 8 on accept.
  - Accept with wr_ptr = 7, or with in_last = 1, sets bank_valid at that edge and forces wr_ptr to 0.
- Directed mode (mode = 1):
  - Target lane = select + 1 for codes 0..7. Codes 8..15 route to lane 1, matching the selector's default.
  - wr_ptr holds.
  - Writing a lane whose lane_valid bit is already 1 overwrites the data and pulses err_overwrite for one cycle.
  - bank_valid sets at the edge where lane_valid becomes 8'hFF, or on accept with in_last = 1.
- in_ready register:
  - Next value = !(next bank_valid).
  - in_ready drops in the same edge that sets bank_valid, so no word is accepted into a completed bank.
- bank_ack:
  - With bank_valid = 1: at the next edge bank_valid = 0, lane_valid = 0 and in_ready = 1. out_x hold their values and are not cleared.
  - With bank_valid = 0: ignored.
  - bank_ack with a simultaneous in_valid: the word waits, because in_ready is still 0 that cycle.
- Partial bank (in_last): lanes not written keep their stale data with lane_valid = 0. The consumer must qualify with lane_valid.
- Mode switch mid-bank: allowed. wr_ptr is not reset, and lane_valid accumulates across modes.
- Throughput: 1 word per cycle while filling. Minimum 1 bubble per bank: the ack edge, then refill.

Decomposition:
- Shared package demux8_pkg holds:
  - DATA_W, SEL_W, LANES
  - MODE_AUTO = 1'b0, MODE_DIR = 1'b1
  - LANE_ALL = 8'hFF
- One sub-module, demux8_sel_decode: combinational 4-bit code to 8-bit one-hot. Out-of-range codes give 8'b0000_0001. It is reused for both the wr_ptr and select paths.
- Lane registers, the wr_ptr counter and the bank handshake stay in the top module.

Test Plan:
- Reset, then auto mode: 8 back-to-back words 0x11..0x88, bank_ack held 0 → out_1 = 0x11 … out_8 = 0x88; bank_valid = 1 and in_ready = 0 at the 8th accept edge; lane_valid = 8'hFF; wr_ptr = 0.
- Backpressure: with bank_valid = 1, hold in_valid = 1 (data 0x99) for 5 cycles, then pulse bank_ack → 0x99 is not accepted until in_ready = 1, then lands in out_1. out_2..out_8 still hold the old 0x22..0x88 and lane_valid = 8'h01.
- Directed mode: select = 7, 3, 12, 0 (data A, B, C, D) → out_8 = A, out_4 = B, out_1 = C then D. err_overwrite pulses exactly once, on D. lane_valid = 8'h89.
- in_last in auto mode: 3 words, in_last on the 3rd → bank_valid = 1 with lane_valid = 8'h07; wr_ptr = 0 after that edge.
- Reset mid-bank: after 5 auto accepts, drive rst_n low for 1 cycle → all outputs 0, in_ready = 0 for that cycle, 1 afterwards; the next word goes to out_1.
- Random in_valid and bank_ack over 10k cycles, scoreboarded against a reference model → no lost or duplicated words, and in_ready never 1 while bank_valid = 1.
